// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared XLEN width, RV32M divide op encodings and divider FSM states
`ifndef XLEN
`define XLEN 32
`endif

package div_unit_pkg;

    localparam int XLEN = `XLEN;

    // funct3[1:0] of the RV32M divide group
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - 32-cycle restoring divider for RV32M DIV/DIVU/REM/REMU
`ifndef XLEN
`define XLEN 32
`endif

module div_unit
    import div_unit_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic [1:0]        i_op,
    input  logic [`XLEN-1:0]  i_Ra,
    input  logic [`XLEN-1:0]  i_Rb,
    input  logic              i_kill,
    output logic              o_busy,
    output logic              o_done,
    output logic [`XLEN-1:0]  o_result
);

    div_state_e        state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [`XLEN-1:0]  quo_q, quo_d;
    logic [`XLEN-1:0]  dvs_q, dvs_d;
    logic [`XLEN-1:0]  rem_q, rem_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [`XLEN-1:0]  result_q, result_d;

    logic              sgn_a, sgn_b, is_ovf;
    logic [`XLEN-1:0]  mag_a, mag_b;
    logic [`XLEN:0]    rem_shift, diff;
    logic              qbit;
    logic [`XLEN-1:0]  rem_next, quo_next;

    always_comb begin
        sgn_a  = op_is_signed(i_op) & i_Ra[`XLEN-1];
        sgn_b  = op_is_signed(i_op) & i_Rb[`XLEN-1];
        mag_a  = sgn_a ? -i_Ra : i_Ra;
        mag_b  = sgn_b ? -i_Rb : i_Rb;
        is_ovf = op_is_signed(i_op) && (i_Ra == {1'b1, {(`XLEN-1){1'b0}}})
                 && (i_Rb == {`XLEN{1'b1}});

        // Quotient bits shift in from the bottom while dividend bits shift out the top
        rem_shift = {rem_q, quo_q[`XLEN-1]};
        diff      = rem_shift - {1'b0, dvs_q};
        qbit      = ~diff[`XLEN];
        rem_next  = qbit ? diff[`XLEN-1:0] : rem_shift[`XLEN-1:0];
        quo_next  = {quo_q[`XLEN-2:0], qbit};

        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        case (state_q)
            ST_CALC: begin
                quo_d = quo_next;
                rem_d = rem_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d  = ST_DONE;
                    result_d = op_is_rem(op_q) ? (neg_rem_q ? -rem_next : rem_next)
                                               : (neg_quo_q ? -quo_next : quo_next);
                end
            end
            default: begin
                if (i_start) begin
                    op_d      = i_op;
                    quo_d     = mag_a;
                    dvs_d     = mag_b;
                    rem_d     = '0;
                    cnt_d     = 5'd0;
                    neg_quo_d = sgn_a ^ sgn_b;
                    neg_rem_d = sgn_a;
                    if (i_Rb == '0) begin
                        state_d  = ST_DONE;
                        result_d = op_is_rem(i_op) ? i_Ra : {`XLEN{1'b1}};
                    end else if (is_ovf) begin
                        state_d  = ST_DONE;
                        result_d = op_is_rem(i_op) ? '0 : {1'b1, {(`XLEN-1){1'b0}}};
                    end else begin
                        state_d = ST_CALC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        // A flush discards everything, including a result about to be written
        if (i_kill) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end

        busy_d = (state_d == ST_CALC);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed-vector bench for div_unit
`timescale 1ns/1ps

module tb_div_unit;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_Ra;
    logic [31:0] i_Rb;
    logic        i_kill;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result;

    int n_vec  = 0;
    int n_miss = 0;

    div_unit dut (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_start  (i_start),
        .i_op     (i_op),
        .i_Ra     (i_Ra),
        .i_Rb     (i_Rb),
        .i_kill   (i_kill),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_result (o_result)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Starts an op in the current cycle and returns in the o_done cycle (or at timeout)
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
        int cyc;
        i_start = 1'b1; i_op = op; i_Ra = a; i_Rb = b;
        tick();
        i_start = 1'b0; i_Ra = 32'hDEAD_BEEF; i_Rb = 32'h0000_0001;
        cyc = 1;
        while (!o_done && cyc < 40) begin
            tick();
            cyc++;
        end
        check({tag, "_lat"}, cyc, exp_lat);
        check({tag, "_res"}, o_result, exp_res);
    endtask

    // mode 0: ignored start only, 1: kill in cycle 10, 2: reset in cycle 10
    task automatic abort_test(input string tag, input int mode, input logic [31:0] exp_res);
        bit saw_done = 1'b0;
        int done_cyc = 0;
        for (int c = 0; c < 45; c++) begin
            case (c)
                0: begin i_start = 1'b1; i_op = 2'b01; i_Ra = 32'd100; i_Rb = 32'd7; end
                1: i_start = 1'b0;
                5: begin i_start = 1'b1; i_op = 2'b11; i_Ra = 32'd200; i_Rb = 32'd3; end
                6: i_start = 1'b0;
                10: begin
                    check({tag, "_busy10"}, {31'd0, o_busy}, 32'd1);
                    if (mode == 1) i_kill = 1'b1;
                    if (mode == 2) i_rstn = 1'b0;
                end
                11: begin
                    i_kill = 1'b0;
                    i_rstn = 1'b1;
                    if (mode != 0) check({tag, "_busy11"}, {31'd0, o_busy}, 32'd0);
                end
                default: ;
            endcase
            if (c > 0 && o_done && !saw_done) begin
                saw_done = 1'b1;
                done_cyc = c;
                if (mode == 0) check({tag, "_res"}, o_result, exp_res);
            end
            tick();
        end
        if (mode == 0) begin
            check({tag, "_lat"}, done_cyc, 33);
        end else begin
            check({tag, "_nodone"}, {31'd0, saw_done}, 32'd0);
            check({tag, "_res"}, o_result, exp_res);
        end
    endtask

    initial begin
        i_rstn = 1'b0; i_start = 1'b0; i_op = 2'b00; i_Ra = '0; i_Rb = '0; i_kill = 1'b0;
        tick(); tick();
        i_rstn = 1'b1;
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_result", o_result, 32'd0);
        tick();

        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 33, 32'd14); tick();
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 33, 32'd2); tick();
        run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD); tick();
        run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF); tick();
        run_op("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD); tick();
        run_op("divu_5_0", 2'b01, 32'd5, 32'd0, 1, 32'hFFFF_FFFF); tick();
        run_op("rem_m7_0", 2'b10, 32'hFFFF_FFF9, 32'd0, 1, 32'hFFFF_FFF9); tick();
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000); tick();
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0); tick();
        run_op("divu_max_10", 2'b01, 32'hFFFF_FFFF, 32'd10, 33, 32'h1999_9999); tick();
        run_op("remu_max_10", 2'b11, 32'hFFFF_FFFF, 32'd10, 33, 32'd5); tick();
        run_op("div_min_1", 2'b00, 32'h8000_0000, 32'd1, 33, 32'h8000_0000); tick();
        run_op("divu_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0); tick();

        abort_test("ignore_start", 0, 32'd14);
        abort_test("kill", 1, 32'd14);
        abort_test("reset", 2, 32'd0);

        run_op("b2b_divu", 2'b01, 32'd100, 32'd7, 33, 32'd14);
        run_op("b2b_remu", 2'b11, 32'd100, 32'd7, 33, 32'd2);
        tick();
        check("idle_after_b2b", {31'd0, o_done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: i_clk rising edge, i_rstn sampled only on that edge.
REQ-002 Port i_clk  input  1  clock, all state updates on its rising edge.
REQ-003 Port i_rstn  input  1  synchronous active-low reset.
REQ-004 Port i_start  input  1  request; sampled only when o_busy is low.
REQ-005 Port i_op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0] of RV32M).
REQ-006 Port i_Ra  input  `XLEN  dividend.
REQ-007 Port i_Rb  input  `XLEN  divisor.
REQ-008 Port i_kill  input  1  pipeline flush; aborts any operation in progress.
REQ-009 Port o_busy  output  1  high while an operation is iterating.
REQ-010 Port o_done  output  1  one-cycle pulse; o_result is valid in that cycle.
REQ-011 Port o_result  output  `XLEN  quotient or remainder per latched i_op.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC, DONE; o_busy is high only in CALC; o_done is high only in DONE.
REQ-013 IDLE or DONE with i_start=1 and i_kill=0 SHALL latch i_op, |i_Ra|, |i_Rb| (magnitudes only for signed ops), the result signs and a 5-bit counter at 0, then move to CALC; otherwise DONE->IDLE.
REQ-014 CALC SHALL perform one restoring shift-subtract step per cycle for exactly 32 cycles, then enter DONE.
REQ-015 Timing: i_start sampled in cycle 0 -> CALC in cycles 1..32 -> o_done high in cycle 33.
REQ-016 On entry to DONE, o_result SHALL be registered with signs applied: quotient negated if dividend and divisor signs differ (DIV); remainder takes dividend sign (REM).
REQ-017 Divide by zero SHALL skip CALC: o_done in cycle 1; quotient = 0xFFFFFFFF (DIV, DIVU); remainder = i_Ra (REM, REMU).
REQ-018 Signed overflow (DIV/REM, i_Ra=0x80000000, i_Rb=0xFFFFFFFF) SHALL skip CALC: o_done in cycle 1; quotient 0x80000000; remainder 0.
REQ-019 i_start while o_busy is high SHALL be ignored and SHALL NOT alter latched operands.
REQ-020 i_kill=1 in any state SHALL force IDLE at the next edge, with no o_done for the aborted operation; i_kill takes priority over a simultaneous i_start.
REQ-021 o_result SHALL hold its last value until the next DONE entry; inputs are not required to stay stable after the start cycle.
REQ-022 All arithmetic SHALL be `XLEN bits with a (`XLEN+1)-bit partial remainder for the subtract; no other width extension.

Reset
REQ-023 i_rstn=0 at an edge SHALL set state IDLE, o_busy 0, o_done 0, o_result 0, and counter 0.
REQ-024 Reset SHALL abort an operation in progress with no o_done pulse; reset has priority over i_kill and i_start.

Structure
REQ-025 The DIV/DIVU/REM/REMU op encodings and FSM state encodings SHALL live in a shared defines header next to the ALU op defines; `XLEN comes from the global defines header.
REQ-026 The block SHALL be a single module with no sub-module; the step logic SHALL be inline.

Verification
REQ-027 DIVU 100/7: start in cycle 0 -> o_done in cycle 33, o_result=14; REMU with the same operands -> 2.
REQ-028 DIV 0xFFFFFFF9/2 (-7/2) -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
REQ-029 DIVU 5/0 -> o_done in cycle 1, 0xFFFFFFFF; REM 0xFFFFFFF9/0 -> 0xFFFFFFF9.
REQ-030 DIV 0x80000000/0xFFFFFFFF -> o_done in cycle 1, 0x80000000; REM with the same operands -> 0.
REQ-031 Start DIVU 100/7, assert i_start with new operands in cycle 5 (ignored), assert i_kill in cycle 10 -> o_busy low from cycle 11, no o_done; repeat with i_rstn=0 in cycle 10 -> same result, o_result=0.
REQ-032 Back-to-back: i_start in the o_done cycle of a DIVU 100/7 op with REMU 100/7 -> second o_done exactly 33 cycles later, o_result=2.
